// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Operands are registered in EXEC and the result is held in RESP until the owner takes it.
module alu_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [3:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [3:0]    req1_op,
    output logic          resp0_valid,
    input  logic          resp0_ready,
    output logic          resp1_valid,
    input  logic          resp1_ready,
    output logic [DW-1:0] resp_c,
    output logic          resp_zero,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_c,
    input  logic          alu_zero,
    output logic          busy
);
    localparam logic [3:0] ALU_NOP = 4'b0000;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_n;
    logic          last_grant, owner, sel, accept, done;
    logic [DW-1:0] opa, opb;
    logic [3:0]    opc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            opa        <= '0;
            opb        <= '0;
            opc        <= ALU_NOP;
            resp_c     <= '0;
            resp_zero  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n != IDLE;
            if (accept) begin
                opa        <= sel ? req1_a : req0_a;
                opb        <= sel ? req1_b : req0_b;
                opc        <= sel ? req1_op : req0_op;
                owner      <= sel;
                last_grant <= sel;
            end
            if (state == EXEC) begin
                resp_c    <= alu_c;
                resp_zero <= alu_zero;
            end
        end
    end

    always_comb begin
        // Under contention the requester that did not win last time goes first
        sel         = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready  = rstn && state == IDLE && req0_valid && !sel;
        req1_ready  = rstn && state == IDLE && req1_valid && sel;
        accept      = req0_ready || req1_ready;
        resp0_valid = state == RESP && !owner;
        resp1_valid = state == RESP && owner;
        done        = owner ? resp1_valid && resp1_ready : resp0_valid && resp0_ready;
        alu_a       = state == EXEC ? opa : '0;
        alu_b       = state == EXEC ? opb : '0;
        alu_op      = state == EXEC ? opc : ALU_NOP;
        state_n     = state == IDLE ? (accept ? EXEC : IDLE) :
                      state == EXEC ? RESP :
                      (done ? IDLE : RESP);
    end
endmodule
